// File: rtl/traffic_light_seq.sv
// N-direction round-robin traffic-light sequencer: GREEN -> YELLOW -> ALL_RED per direction.
// Optional pedestrian-call / early-end-of-green logic is built when TRAFFIC_PED_REQ_EN is defined.
module traffic_light_seq #(
  parameter int unsigned NUM_DIR  = 2,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned GREEN_T  = 10,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 1,
`ifdef TRAFFIC_PED_REQ_EN
  parameter int unsigned PED_GREEN_T = 3,
`endif
  localparam int unsigned DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                     clk,
  input  logic                     resetSW_n,
  input  logic                     tick,
  input  logic                     hold,
`ifdef TRAFFIC_PED_REQ_EN
  input  logic [NUM_DIR-1:0]       ped_req,
  output logic [NUM_DIR-1:0]       ped_pending,
`endif
  output logic [NUM_DIR*CNT_W-1:0] count,
  output logic [NUM_DIR*3-1:0]     lamps,
  output logic [DIR_W-1:0]         active_dir,
  output logic [1:0]               phase
);

  typedef enum logic [1:0] {
    StGreen  = 2'd0,
    StYellow = 2'd1,
    StAllRed = 2'd2
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [DIR_W-1:0]   dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               advance;
  logic               last_tick;

  assign advance   = tick && !hold;
  assign last_tick = (cnt_q == CNT_W'(1));

`ifdef TRAFFIC_PED_REQ_EN
  logic [NUM_DIR-1:0] ped_q, ped_d;
  logic               ped_other;
  logic               enter_green;

  assign enter_green = advance && last_tick && (phase_q == StAllRed);

  // A call from any direction other than the one currently holding green.
  always_comb begin
    ped_other = 1'b0;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      if (ped_q[d] && (DIR_W'(d) != dir_q)) begin
        ped_other = 1'b1;
      end
    end
  end

  // Clearing on entry to GREEN is applied last so it wins over a same-cycle request.
  always_comb begin
    ped_d = ped_q;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      if (ped_req[d] && !((DIR_W'(d) == dir_q) && (phase_q != StAllRed))) begin
        ped_d[d] = 1'b1;
      end
      if (enter_green && (DIR_W'(d) == dir_d)) begin
        ped_d[d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetSW_n) begin
      ped_q <= '0;
    end else begin
      ped_q <= ped_d;
    end
  end

  assign ped_pending = ped_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetSW_n) begin
      phase_q <= StGreen;
      dir_q   <= '0;
      cnt_q   <= CNT_W'(GREEN_T);
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    phase_d = phase_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (advance) begin
      if (!last_tick) begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef TRAFFIC_PED_REQ_EN
        if ((phase_q == StGreen) && ped_other && (cnt_q > CNT_W'(PED_GREEN_T))) begin
          cnt_d = CNT_W'(PED_GREEN_T);
        end
`endif
      end else begin
        unique case (phase_q)
          StGreen: begin
            phase_d = StYellow;
            cnt_d   = CNT_W'(YELLOW_T);
          end
          StYellow: begin
            phase_d = StAllRed;
            cnt_d   = CNT_W'(ALLRED_T);
          end
          StAllRed: begin
            phase_d = StGreen;
            cnt_d   = CNT_W'(GREEN_T);
            dir_d   = (dir_q == DIR_W'(NUM_DIR - 1)) ? '0 : dir_q + DIR_W'(1);
          end
          default: begin
            phase_d = StGreen;
            cnt_d   = CNT_W'(GREEN_T);
          end
        endcase
      end
    end
  end

  // Output decode: registers only, every non-active direction blank and red.
  always_comb begin
    count = '1;
    lamps = '0;
    for (int unsigned d = 0; d < NUM_DIR; d++) begin
      lamps[d*3 +: 3] = 3'b100;
      if (DIR_W'(d) == dir_q) begin
        unique case (phase_q)
          StGreen: begin
            lamps[d*3 +: 3]         = 3'b001;
            count[d*CNT_W +: CNT_W] = cnt_q;
          end
          StYellow: begin
            lamps[d*3 +: 3]         = 3'b010;
            count[d*CNT_W +: CNT_W] = cnt_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign active_dir = dir_q;
  assign phase      = phase_q;

endmodule
